// File: rtl/key_state_arbiter.sv
// Round-robin arbiter granting NREQ requesters masked write access to one shared
// key-state register, with a priority whole-register clear.
module key_state_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  input  logic [NREQ*WIDTH-1:0]   wmask,
  input  logic                    clr,
  input  logic [WIDTH-1:0]        reg_q,
  output logic [WIDTH-1:0]        reg_d,
  output logic                    reg_en,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int unsigned GW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOAD, ACK, CLEAR} state_t;

  state_t           state;
  logic             clr_pend;
  logic [GW-1:0]    last_grant;
  logic [WIDTH-1:0] data_l;
  logic [WIDTH-1:0] mask_l;
  logic [GW-1:0]    cand;
  logic [GW-1:0]    winner;
  logic             any_req;

  // First set request searching upward from the requester after the last one served.
  always_comb begin
    cand    = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = GW'((32'(last_grant) + k) % NREQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // Register write data follows the current register except in the load/clear cycle.
  always_comb begin
    reg_d = reg_q;
    if (state == LOAD) begin
      reg_d = (reg_q & ~mask_l) | (data_l & mask_l);
    end else if (state == CLEAR) begin
      reg_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      reg_en     <= 1'b0;
      ack        <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      clr_pend   <= 1'b0;
      last_grant <= GW'(NREQ - 1);
      data_l     <= '0;
      mask_l     <= '0;
    end else begin
      reg_en <= 1'b0;
      ack    <= '0;
      // A clear seen while busy is remembered and wins the next idle cycle.
      if (clr && (state != IDLE)) begin
        clr_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (clr || clr_pend) begin
            state    <= CLEAR;
            reg_en   <= 1'b1;
            busy     <= 1'b1;
            grant_id <= '0;
            clr_pend <= 1'b0;
          end else if (any_req) begin
            state    <= LOAD;
            reg_en   <= 1'b1;
            busy     <= 1'b1;
            grant_id <= winner;
            data_l   <= wdata[32'(winner)*WIDTH +: WIDTH];
            mask_l   <= wmask[32'(winner)*WIDTH +: WIDTH];
          end
        end
        LOAD: begin
          state         <= ACK;
          ack[grant_id] <= 1'b1;
        end
        ACK: begin
          state      <= IDLE;
          busy       <= 1'b0;
          last_grant <= grant_id;
          grant_id   <= '0;
        end
        CLEAR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_state_arbiter.sv
// Scoreboard bench for key_state_arbiter: a transaction-level model predicts each
// register load and acknowledge; an independent monitor compares them.
module tb_key_state_arbiter;

  localparam int unsigned W = 64;
  localparam int unsigned N = 4;

  typedef struct {
    bit          is_clr;
    int          id;
    logic [W-1:0] value;
    int          cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N*W-1:0] wmask = '0;
  logic           clr = 1'b0;
  logic [W-1:0]   reg_q = '0;
  logic [W-1:0]   reg_d;
  logic           reg_en;
  logic [N-1:0]   ack;
  logic           busy;
  logic [1:0]     grant_id;

  key_state_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .wmask(wmask), .clr(clr),
    .reg_q(reg_q), .reg_d(reg_d), .reg_en(reg_en), .ack(ack), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Shared register owned by the environment.
  always @(posedge clk) if (reg_en) reg_q <= reg_d;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  exp_t exp_q[$];
  exp_t ack_q[$];
  int grant_log[$];
  int gcyc_log[$];
  logic [N-1:0] last_ack = '0;
  logic [N-1:0] active = '0;
  bit hold_all = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [W-1:0] act,
                     input logic [W-1:0] expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: requests served one at a time, three cycles per write, two per clear.
  int mlast = N - 1;
  int busy_cnt = 0;
  bit pend = 1'b0;
  int pl = 0;
  logic [W-1:0] mreg = '0;
  logic [W-1:0] mreg_before = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (pl > 0) mreg = mreg_before;
      pl = 0;
      busy_cnt = 0;
      pend = 1'b0;
      mlast = N - 1;
      exp_q.delete();
    end else begin
      if (pl > 0) pl--;
      if (busy_cnt > 0) begin
        if (clr) pend = 1'b1;
        busy_cnt--;
      end else if (clr || pend) begin
        pend = 1'b0;
        mreg_before = mreg;
        mreg = '0;
        pl = 2;
        busy_cnt = 1;
        exp_q.push_back('{1'b1, 0, '0, cyc + 1});
      end else if (req != '0) begin
        int w;
        logic [W-1:0] d, m;
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req[(mlast + k) % N]) w = (mlast + k) % N;
        end
        d = wdata[w*W +: W];
        m = wmask[w*W +: W];
        mreg_before = mreg;
        mreg = (mreg & ~m) | (d & m);
        mlast = w;
        pl = 2;
        busy_cnt = 2;
        exp_q.push_back('{1'b0, w, mreg, cyc + 1});
      end
    end
  end

  // Monitor: compares every load and acknowledge the DUT presents.
  always @(negedge clk) begin
    last_ack = ack;
    if (!reset) begin
      ack_q.delete();
    end else begin
      if (reg_en) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_reg_en", reg_d, '0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(cyc == e.cyc, "reg_en_cycle", W'(cyc), W'(e.cyc));
          chk(reg_d == e.value, "reg_d", reg_d, e.value);
          if (e.is_clr) begin
            chk(grant_id == 2'd0, "grant_id_clear", W'(grant_id), '0);
          end else begin
            chk(grant_id == 2'(e.id), "grant_id", W'(grant_id), W'(e.id));
            e.cyc = cyc + 1;
            ack_q.push_back(e);
            grant_log.push_back(int'(grant_id));
            gcyc_log.push_back(cyc);
          end
        end
      end else begin
        chk(reg_d == reg_q, "reg_d_hold", reg_d, reg_q);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          chk(1'b0, "missing_reg_en", '0, W'(exp_q[0].cyc));
          void'(exp_q.pop_front());
        end
      end
      if (ack != '0) begin
        if (ack_q.size() == 0) begin
          chk(1'b0, "unexpected_ack", W'(ack), '0);
        end else begin
          exp_t a;
          a = ack_q.pop_front();
          chk(ack == (N'(1) << a.id), "ack", W'(ack), W'(N'(1) << a.id));
          chk(cyc == a.cyc, "ack_cycle", W'(cyc), W'(a.cyc));
          chk(reg_q == a.value, "reg_q_in_ack", reg_q, a.value);
        end
      end else begin
        while (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
          chk(1'b0, "missing_ack", '0, W'(ack_q[0].id));
          void'(ack_q.pop_front());
        end
      end
    end
  end

  function automatic logic [W-1:0] rmask();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic raise(input int i, input logic [W-1:0] d, input logic [W-1:0] m);
    wdata[i*W +: W] = d;
    wmask[i*W +: W] = m;
    req[i] = 1'b1;
    active[i] = 1'b1;
  endtask

  task automatic refill(input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (!active[i] && (hold_all || (rnd && $urandom_range(0, 3) == 0)))
        raise(i, {$urandom, $urandom}, rmask());
    end
  endtask

  // One clock of requester behaviour: drop on the edge after ack, maybe re-request.
  task automatic drive_step(input bit rnd);
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (last_ack[i]) begin
        req[i] = 1'b0;
        active[i] = 1'b0;
      end
    end
    refill(rnd);
    if (rnd && $urandom_range(0, 15) == 0) clr = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    logic [W-1:0] d4;

    repeat (3) @(posedge clk);
    #1;
    chk(busy == 1'b0, "reset_busy", W'(busy), '0);
    chk(reg_en == 1'b0, "reset_reg_en", W'(reg_en), '0);
    chk(ack == '0, "reset_ack", W'(ack), '0);
    chk(grant_id == 2'd0, "reset_grant_id", W'(grant_id), '0);
    reset = 1'b1;

    // Single write from requester 1.
    drive_step(1'b0);
    raise(1, 64'h00000000000000AB, 64'hFF);
    repeat (5) drive_step(1'b0);
    chk(reg_q == 64'h00000000000000AB, "single_write", reg_q, 64'hAB);

    // Masked merge.
    raise(2, 64'h0000000000008CAB, '1);
    repeat (5) drive_step(1'b0);
    raise(3, '0, 64'h000000000000F000);
    repeat (5) drive_step(1'b0);
    chk(reg_q == 64'h0000000000000CAB, "masked_merge", reg_q, 64'hCAB);

    // Clear and request in the same idle cycle.
    d4 = {$urandom, $urandom};
    raise(2, d4, '1);
    clr = 1'b1;
    repeat (8) drive_step(1'b0);
    chk(reg_q == d4, "clear_then_write", reg_q, d4);

    // Reset during LOAD.
    raise(3, 64'hDEADBEEF00C0FFEE, '1);
    found = 1'b0;
    for (int t = 0; t < 8 && !found; t++) begin
      @(negedge clk);
      if (reg_en) found = 1'b1;
    end
    chk(found, "load_reached", W'(found), 64'd1);
    chk(busy == 1'b1, "busy_in_load", W'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk(reg_en == 1'b0, "abort_reg_en", W'(reg_en), '0);
    chk(busy == 1'b0, "abort_busy", W'(busy), '0);
    chk(ack == '0, "abort_ack", W'(ack), '0);
    chk(grant_id == 2'd0, "abort_grant_id", W'(grant_id), '0);
    req = '0;
    active = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(reg_q == d4, "abort_no_write", reg_q, d4);
    reset = 1'b1;

    // Fairness with all requesters continuously asking.
    grant_log.delete();
    gcyc_log.delete();
    hold_all = 1'b1;
    refill(1'b0);
    repeat (16) drive_step(1'b0);
    hold_all = 1'b0;
    repeat (6) drive_step(1'b0);
    chk(grant_log.size() >= 5, "fair_count", W'(grant_log.size()), 64'd5);
    if (grant_log.size() >= 5) begin
      int order[5];
      order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++)
        chk(grant_log[i] == order[i], "fair_order", W'(grant_log[i]), W'(order[i]));
      chk(gcyc_log[4] - gcyc_log[0] == 12, "fair_period", W'(gcyc_log[4] - gcyc_log[0]), 64'd12);
    end

    // Random traffic with occasional clears.
    repeat (3000) drive_step(1'b1);
    repeat (20) drive_step(1'b0);
    chk(exp_q.size() == 0, "loads_outstanding", W'(exp_q.size()), '0);
    chk(ack_q.size() == 0, "acks_outstanding", W'(ack_q.size()), '0);
    chk(active == '0, "requests_unserved", W'(active), '0);
    chk(busy == 1'b0, "final_idle", W'(busy), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_state_arbiter.md
KEY_STATE_ARBITER -- requirements
Module: key_state_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64: width of the shared key-state register and of all data/mask buses.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters, 2..8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, NREQ bits: per-requester write request, level.
REQ-006 SHALL have port wdata, input, NREQ*WIDTH bits: requester i data in slice [i*WIDTH +: WIDTH].
REQ-007 SHALL have port wmask, input, NREQ*WIDTH bits: requester i bit mask, same slicing; 1 = bit written.
REQ-008 SHALL have port clr, input, 1 bit: request to clear the whole register.
REQ-009 SHALL have port reg_q, input, WIDTH bits: current contents of the shared register.
REQ-010 SHALL have port reg_d, output, WIDTH bits: next value presented to the shared register.
REQ-011 SHALL have port reg_en, output, 1 bit: register load enable, one cycle per transaction.
REQ-012 SHALL have port ack, output, NREQ bits: one-hot, one-cycle completion pulse to the served requester.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port grant_id, output, $clog2(NREQ) bits: index of requester being served; 0 when idle or clearing.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, ACK, CLEAR.
REQ-016 IDLE: clr=1 -> CLEAR (priority over all req); else any req bit set -> LOAD; else stay IDLE.
REQ-017 On IDLE->LOAD, SHALL latch winner index, its wdata and its wmask; later changes on those inputs ignored.
REQ-018 Winner SHALL be chosen round-robin: first set req bit searching upward from (last_grant+1) mod NREQ, wrapping.
REQ-019 LOAD: reg_d = (reg_q & ~mask_l) | (data_l & mask_l); reg_en=1 for exactly this cycle; next state ACK.
REQ-020 ACK: ack[grant_id]=1 for exactly this cycle; last_grant updated to grant_id; next state IDLE.
REQ-021 CLEAR: reg_d=0, reg_en=1 for one cycle, no ack bit asserted, last_grant unchanged; next state IDLE.
REQ-022 Latency: req sampled in IDLE at edge k -> reg_en high cycle k+1 -> ack high cycle k+2 -> IDLE at edge k+3; new reg_q visible in ack cycle.
REQ-023 Requester SHALL hold req, wdata, wmask stable until ack and drop req the edge after ack; a req still high in the cycle after ack is treated as a new request.
REQ-024 reg_d SHALL equal reg_q and reg_en SHALL be 0 in IDLE and ACK states.
REQ-025 wmask all-zero SHALL still complete full handshake with reg_d=reg_q (no-op write).
REQ-026 Requests arriving while busy SHALL wait; none lost, none served twice per grant.
REQ-027 clr asserted while busy SHALL be held pending and taken on the next IDLE cycle ahead of any req.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, reg_en=0, ack=0, busy=0, grant_id=0, pending clr=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-029 reset asserted mid-transaction SHALL abort it with no ack; reg_en deasserts asynchronously.
REQ-030 After reset release, first edge SHALL evaluate inputs as in IDLE.

Verification
REQ-031 Single write: reg_q=0, req[1]=1, wdata1=64'h00000000000000AB, wmask1=64'hFF -> reg_en one cycle later with reg_d=64'h00000000000000AB, ack=4'b0010 next cycle.
REQ-032 Masked merge: reg_q=64'h0000000000008CAB, wdata=0, wmask=64'h000000000000F000 -> reg_d=64'h0000000000000CAB.
REQ-033 Fairness: req=4'b1111 held (re-asserted after each ack) -> grant order 0,1,2,3,0; each served once per 12 cycles.
REQ-034 Clear priority: clr=1 and req[2]=1 same IDLE cycle -> CLEAR first (reg_d=0, no ack), then requester 2 served.
REQ-035 Reset mid-LOAD: reset=0 during LOAD -> reg_en=0 immediately, no ack; after release req[0] wins first.
